// File: rtl/sha1_pkg.sv
// Shared SHA-1 constants, round helpers and the guesser state encoding.
package sha1_pkg;

  localparam int SHA1_ROUNDS = 80;

  localparam logic [159:0] SHA1_IV =
    160'h67452301_efcdab89_98badcfe_10325476_c3d2e1f0;

  // Indexed by round group: [0] rounds 0-19 ... [3] rounds 60-79.
  localparam logic [3:0][31:0] SHA1_K =
    {32'hca62c1d6, 32'h8f1bbcdc, 32'h6ed9eba1, 32'h5a827999};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [1:0] sha1_group(input logic [6:0] t);
    if (t < 7'd20)      return 2'd0;
    else if (t < 7'd40) return 2'd1;
    else if (t < 7'd60) return 2'd2;
    else                return 2'd3;
  endfunction

  function automatic logic [31:0] sha1_f(input logic [1:0] grp, input logic [31:0] b,
                                         input logic [31:0] c, input logic [31:0] d);
    case (grp)
      2'd0:    return (b & c) | (~b & d);
      2'd2:    return (b & c) | (b & d) | (c & d);
      default: return b ^ c ^ d;
    endcase
  endfunction

  function automatic logic [31:0] sha1_k(input logic [1:0] grp);
    return SHA1_K[grp];
  endfunction

  function automatic logic [31:0] sha1_rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

endpackage

// File: rtl/sha1_block.sv
// SHA-1 compression datapath: one round per clock over a 16-word rolling schedule.
// load_i seeds a..e and W; en_i advances rounds until rounds_done_o.
module sha1_block
  import sha1_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic         en_i,
  input  logic [159:0] ctx_i,
  input  logic [511:0] block_i,
  output logic         rounds_done_o,
  output logic [159:0] digest_o
);

  localparam logic [6:0] LAST_ROUND = 7'(SHA1_ROUNDS);

  logic [6:0]        round_q, round_d;
  logic [31:0]       a_q, b_q, c_q, d_q, e_q;
  logic [31:0]       a_d, b_d, c_d, d_d, e_d;
  // w_q[15] is the word consumed this round; fresh schedule words enter at w_q[0].
  logic [15:0][31:0] w_q, w_d;
  logic [1:0]        grp;
  logic [31:0]       f_w, k_w, t_w, w_next;

  assign rounds_done_o = (round_q == LAST_ROUND);

  assign digest_o = {ctx_i[159:128] + a_q, ctx_i[127:96] + b_q, ctx_i[95:64] + c_q,
                     ctx_i[63:32] + d_q, ctx_i[31:0] + e_q};

  always_comb begin
    grp    = sha1_group(round_q);
    f_w    = sha1_f(grp, b_q, c_q, d_q);
    k_w    = sha1_k(grp);
    t_w    = sha1_rotl(a_q, 5) + f_w + e_q + k_w + w_q[15];
    w_next = sha1_rotl(w_q[2] ^ w_q[7] ^ w_q[13] ^ w_q[15], 1);

    round_d = round_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    d_d     = d_q;
    e_d     = e_q;
    w_d     = w_q;

    if (load_i) begin
      round_d                   = '0;
      {a_d, b_d, c_d, d_d, e_d} = ctx_i;
      w_d                       = block_i;
    end else if (en_i && !rounds_done_o) begin
      round_d = round_q + 7'd1;
      a_d     = t_w;
      b_d     = a_q;
      c_d     = sha1_rotl(b_q, 30);
      d_d     = c_q;
      e_d     = d_q;
      w_d     = {w_q[14:0], w_next};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      round_q                   <= LAST_ROUND;
      {a_q, b_q, c_q, d_q, e_q} <= SHA1_IV;
      w_q                       <= '0;
    end else begin
      round_q <= round_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      d_q     <= d_d;
      e_q     <= e_d;
      w_q     <= w_d;
    end
  end

endmodule

// File: rtl/sha1_guesser.sv
// Nonce search over SHA-1: hashes every nonce inserted at bit 64 and flags masked matches.
// Option SHA1_GUESSER_EARLY_STOP_EN: stop at the first matching nonce.
//   state   | meaning
//   IDLE    | waiting for start after reset
//   RUN     | 80 rounds plus one finalize cycle per nonce
//   DONE    | search finished, outputs held until the next start
module sha1_guesser
  import sha1_pkg::*;
#(
  parameter int NONCE_SIZE = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [159:0]          context_in,
  input  logic [511:0]          block_in,
  input  logic [159:0]          target,
  input  logic [159:0]          target_mask,
  output logic                  hash,
  output logic                  match,
  output logic                  done,
  output logic [NONCE_SIZE-1:0] nonce,
  output logic [511:0]          block_out,
  output logic [159:0]          context_out
);

  state_e                state_q, state_d;
  logic [NONCE_SIZE-1:0] nonce_w_q, nonce_w_d;
  logic [511:0]          blk_q, blk_d;
  logic [159:0]          ctx_q, ctx_d;
  logic [159:0]          tgt_q, tgt_d;
  logic [159:0]          mask_q, mask_d;
  logic                  hash_q, hash_d;
  logic                  match_q, match_d;
  logic                  done_q, done_d;
  logic [NONCE_SIZE-1:0] nonce_q, nonce_d;
  logic [511:0]          blk_out_q, blk_out_d;
  logic [159:0]          ctx_out_q, ctx_out_d;

  logic                  blk_load, blk_run, rounds_done, hit, stop;
  logic [NONCE_SIZE-1:0] nonce_nx;
  logic [511:0]          cand_blk, cur_blk;
  logic [159:0]          seed_ctx, digest;

  assign nonce_nx = nonce_w_q + NONCE_SIZE'(1);
  assign hit      = (((digest ^ tgt_q) & mask_q) == '0);

  // Outside RUN the seed comes straight from the inputs so nonce 0 starts on the start edge.
  always_comb begin
    cand_blk                     = (state_q == ST_RUN) ? blk_q : block_in;
    cand_blk[64 +: NONCE_SIZE]   = (state_q == ST_RUN) ? nonce_nx : '0;
    cur_blk                      = blk_q;
    cur_blk[64 +: NONCE_SIZE]    = nonce_w_q;
    seed_ctx                     = (state_q == ST_RUN) ? ctx_q : context_in;
  end

  sha1_block u_block (
    .clk          (clk),
    .reset        (reset),
    .load_i       (blk_load),
    .en_i         (blk_run),
    .ctx_i        (seed_ctx),
    .block_i      (cand_blk),
    .rounds_done_o(rounds_done),
    .digest_o     (digest)
  );

  always_comb begin
    state_d   = state_q;
    nonce_w_d = nonce_w_q;
    blk_d     = blk_q;
    ctx_d     = ctx_q;
    tgt_d     = tgt_q;
    mask_d    = mask_q;
    hash_d    = 1'b0;
    match_d   = 1'b0;
    done_d    = done_q;
    nonce_d   = nonce_q;
    blk_out_d = blk_out_q;
    ctx_out_d = ctx_out_q;
    blk_load  = 1'b0;
    blk_run   = 1'b0;
    stop      = 1'b0;

    case (state_q)
      ST_RUN: begin
        blk_run = 1'b1;
        if (rounds_done) begin
          hash_d    = 1'b1;
          match_d   = hit;
          nonce_d   = nonce_w_q;
          blk_out_d = cur_blk;
          ctx_out_d = digest;
          stop      = (nonce_w_q == '1);
`ifdef SHA1_GUESSER_EARLY_STOP_EN
          stop      = stop | hit;
`endif
          if (stop) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            nonce_w_d = nonce_nx;
            blk_load  = 1'b1;
          end
        end
      end
      default: begin
        if (start) begin
          ctx_d     = context_in;
          blk_d     = block_in;
          tgt_d     = target;
          mask_d    = target_mask;
          nonce_w_d = '0;
          done_d    = 1'b0;
          blk_load  = 1'b1;
          state_d   = ST_RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      nonce_w_q <= '0;
      blk_q     <= '0;
      ctx_q     <= '0;
      tgt_q     <= '0;
      mask_q    <= '0;
      hash_q    <= 1'b0;
      match_q   <= 1'b0;
      done_q    <= 1'b0;
      nonce_q   <= '0;
      blk_out_q <= '0;
      ctx_out_q <= '0;
    end else begin
      state_q   <= state_d;
      nonce_w_q <= nonce_w_d;
      blk_q     <= blk_d;
      ctx_q     <= ctx_d;
      tgt_q     <= tgt_d;
      mask_q    <= mask_d;
      hash_q    <= hash_d;
      match_q   <= match_d;
      done_q    <= done_d;
      nonce_q   <= nonce_d;
      blk_out_q <= blk_out_d;
      ctx_out_q <= ctx_out_d;
    end
  end

  assign hash        = hash_q;
  assign match       = match_q;
  assign done        = done_q;
  assign nonce       = nonce_q;
  assign block_out   = blk_out_q;
  assign context_out = ctx_out_q;

endmodule

// File: tb/tb_sha1_guesser.sv
// Scoreboard bench for sha1_guesser: expected hashes come from a behavioural SHA-1 model.
module tb_sha1_guesser;

  localparam int NS     = 2;
  localparam int NNONCE = 1 << NS;

  localparam logic [159:0] IV  = 160'h67452301_efcdab89_98badcfe_10325476_c3d2e1f0;
  localparam logic [159:0] ABC_DIGEST = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
  localparam logic [511:0] ABC_BLK = {24'h616263, 8'h80, 416'h0, 64'd24};
  localparam logic [159:0] ALL1 = {160{1'b1}};

  logic          clk;
  logic          reset;
  logic          start;
  logic [159:0]  context_in;
  logic [511:0]  block_in;
  logic [159:0]  target;
  logic [159:0]  target_mask;
  logic          hash;
  logic          match;
  logic          done;
  logic [NS-1:0] nonce;
  logic [511:0]  block_out;
  logic [159:0]  context_out;

  sha1_guesser #(.NONCE_SIZE(NS)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .context_in (context_in),
    .block_in   (block_in),
    .target     (target),
    .target_mask(target_mask),
    .hash       (hash),
    .match      (match),
    .done       (done),
    .nonce      (nonce),
    .block_out  (block_out),
    .context_out(context_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int           nonce;
    logic [159:0] digest;
    logic [511:0] blk;
    logic         match;
    logic         last;
    int           when;
  } exp_t;

  exp_t         sb[$];
  exp_t         last_e;
  int           n_cmp = 0;
  int           n_err = 0;
  int           cyc = 0;
  logic [159:0] first_digest;
  logic [511:0] first_blk;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [159:0] sha1_ref(input logic [159:0] h, input logic [511:0] m);
    logic [31:0] w [80];
    logic [31:0] a, b, c, d, e, f, k, t;
    for (int i = 0; i < 16; i++) w[i] = m[511 - 32*i -: 32];
    for (int i = 16; i < 80; i++) begin
      t    = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
      w[i] = {t[30:0], t[31]};
    end
    {a, b, c, d, e} = h;
    for (int i = 0; i < 80; i++) begin
      if (i < 20)      begin f = (b & c) | (~b & d);          k = 32'h5a827999; end
      else if (i < 40) begin f = b ^ c ^ d;                   k = 32'h6ed9eba1; end
      else if (i < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8f1bbcdc; end
      else             begin f = b ^ c ^ d;                   k = 32'hca62c1d6; end
      t = {a[26:0], a[31:27]} + f + e + k + w[i];
      e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = t;
    end
    return {h[159:128] + a, h[127:96] + b, h[95:64] + c, h[63:32] + d, h[31:0] + e};
  endfunction

  function automatic logic [511:0] with_nonce(input logic [511:0] b, input int n);
    logic [511:0] r;
    r = b;
    r[64 +: NS] = NS'(n);
    return r;
  endfunction

  // One negedge per call; every hash strobe is matched against the head of the scoreboard.
  task automatic step(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        if (hash) begin
          if (sb.size() == 0) begin
            check("hash_unexpected", 512'(hash), 512'(0));
          end else begin
            e = sb.pop_front();
            check("hash_cycle", 512'(cyc), 512'(e.when));
            check("nonce", 512'(nonce), 512'(e.nonce));
            check("digest", 512'(context_out), 512'(e.digest));
            check("block_out", block_out, e.blk);
            check("match", 512'(match), 512'(e.match));
            check("done_at_hash", 512'(done), 512'(e.last));
            if (e.nonce == 0) begin
              first_digest = context_out;
              first_blk    = block_out;
            end
            last_e = e;
          end
        end else begin
          check("match_without_hash", 512'(match), 512'(0));
        end
      end
    end
  endtask

  task automatic run_search(input logic [159:0] ctx, input logic [511:0] blk,
                            input logic [159:0] tgt, input logic [159:0] msk, input int hold);
    for (int n = 0; n < NNONCE; n++) begin
      exp_t e;
      e.nonce  = n;
      e.blk    = with_nonce(blk, n);
      e.digest = sha1_ref(ctx, e.blk);
      e.match  = (((e.digest ^ tgt) & msk) == '0);
      e.last   = (n == NNONCE - 1);
`ifdef SHA1_GUESSER_EARLY_STOP_EN
      if (e.match) e.last = 1'b1;
`endif
      e.when   = cyc + 82 + 81 * n;
      sb.push_back(e);
      if (e.last) break;
    end
    context_in  = ctx;
    block_in    = blk;
    target      = tgt;
    target_mask = msk;
    start       = 1'b1;
    step(hold);
    start       = 1'b0;
  endtask

  task automatic wait_search(input string tag);
    int n;
    n = 0;
    while ((sb.size() != 0 || done !== 1'b1) && n < 400) begin
      step(1);
      n++;
    end
    check({tag, "_done"}, 512'(done), 512'(1));
    check({tag, "_drained"}, 512'(sb.size()), 512'(0));
    step(20);
    check({tag, "_done_held"}, 512'(done), 512'(1));
    check({tag, "_nonce_held"}, 512'(nonce), 512'(last_e.nonce));
    check({tag, "_digest_held"}, 512'(context_out), 512'(last_e.digest));
    check({tag, "_block_held"}, block_out, last_e.blk);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_hash"}, 512'(hash), 512'(0));
    check({tag, "_match"}, 512'(match), 512'(0));
    check({tag, "_done"}, 512'(done), 512'(0));
    check({tag, "_nonce"}, 512'(nonce), 512'(0));
    check({tag, "_block_out"}, block_out, 512'(0));
    check({tag, "_context_out"}, 512'(context_out), 512'(0));
  endtask

  function automatic logic [511:0] rand_blk();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    context_in  = '0;
    block_in    = '0;
    target      = '0;
    target_mask = '0;
    step(3);
    check_cleared("reset");
    reset = 1'b0;
    step(5);

    // abc block, low byte of digest (9d) against ff: nonce 0 misses.
    run_search(IV, ABC_BLK, 160'hff, 160'hff, 3);
    wait_search("abc_nomatch");
    check("abc_nonce0_digest", 512'(first_digest), 512'(ABC_DIGEST));

    run_search(IV, ABC_BLK, 160'h9d, 160'hff, 1);
    wait_search("abc_match");
    check("abc_nonce0_block", first_blk, ABC_BLK);
    step(200);

    run_search(IV, ABC_BLK, 160'h0, 160'h0, 1);
    wait_search("mask_zero");

    // Abandon a search after its first hash, then check reset beats a simultaneous start.
    run_search(IV, rand_blk(), 160'h0, ALL1, 1);
    step(120);
    reset = 1'b1;
    step(1);
    check_cleared("mid_reset");
    reset = 1'b0;
    sb.delete();
    step(3);
    reset = 1'b1;
    start = 1'b1;
    step(1);
    reset = 1'b0;
    start = 1'b0;
    check_cleared("reset_vs_start");
    step(150);

    run_search({$urandom, $urandom, $urandom, $urandom, $urandom}, rand_blk(), 160'h0, ALL1, 1);
    wait_search("restart");

    run_search(IV, rand_blk(), 160'h0, ALL1, 1);
    step(100);
    block_in    = rand_blk();
    context_in  = ~IV;
    target_mask = '0;
    start       = 1'b1;
    step(1);
    start       = 1'b0;
    wait_search("start_in_run");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got time limit expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
